next_pc_sequencer: RTL and testbench

- Multi-cycle PC/fetch sequencer. It consumes the 2-bit next-PC select code produced by the control-transfer unit and owns the architectural PC register.
- Issues instruction-memory requests with a valid/ready handshake, captures the response, and presents the instruction to the datapath.
- Sits between instruction memory and the decode/execute datapath of the multicycle core.

---
 rtl/next_pc_sequencer_pkg.sv | 25 ++
 rtl/next_pc_sequencer_mux.sv | 70 +++++++
 rtl/next_pc_sequencer.sv | 120 ++++++++++++
 tb/tb_next_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_sequencer_pkg.sv
// Shared constants and types for the next-PC / fetch sequencer.
// Select encodings, reset PC, NOP encoding and the fetch-state enum live here.
package next_pc_sequencer_pkg;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR  = 2'b10;
    localparam logic [1:0] PC_SEL_TRAP  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ      = 2'b00,
        ST_WAIT_RSP = 2'b01,
        ST_EXEC     = 2'b10,
        ST_HALT     = 2'b11
    } fetch_state_e;

    // A fetch target is legal only when word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_sequencer_mux.sv
// Combinational next-PC select, target arithmetic and alignment check.
// Optional macro NEXT_PC_TRAP_EN enables the trap-vector select.
module next_pc_mux
    import next_pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      next_pc_select,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc_plus_4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] TRAP_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_plus_4_s;
    logic [XLEN-1:0] target_s;
    logic            check_align_s;

    assign pc_plus_4_s = pc + FOUR;

`ifndef NEXT_PC_TRAP_EN
    logic unused_trap_s;
    assign unused_trap_s = ^trap_target;
`endif

    // Select the next PC; the trap vector is forced aligned and bypasses the check.
    always_comb begin
        target_s      = pc_plus_4_s;
        check_align_s = 1'b1;
        case (next_pc_select)
            PC_SEL_PLUS4: begin
                target_s      = pc_plus_4_s;
                check_align_s = 1'b1;
            end
            PC_SEL_IMM: begin
                target_s      = pc + immediate;
                check_align_s = 1'b1;
            end
            PC_SEL_JALR: begin
                target_s      = jalr_target & JALR_MASK;
                check_align_s = 1'b1;
            end
            PC_SEL_TRAP: begin
`ifdef NEXT_PC_TRAP_EN
                target_s      = trap_target & TRAP_MASK;
                check_align_s = 1'b0;
`else
                target_s      = pc_plus_4_s;
                check_align_s = 1'b1;
`endif
            end
            default: begin
                target_s      = pc_plus_4_s;
                check_align_s = 1'b1;
            end
        endcase
    end

    assign pc_plus_4  = pc_plus_4_s;
    assign next_pc    = target_s;
    assign misaligned = check_align_s & is_misaligned(target_s[1:0]);

endmodule

// File: rtl/next_pc_sequencer.sv
// Multi-cycle fetch sequencer owning the architectural PC and instruction register.
// Optional macro NEXT_PC_TRAP_EN enables select 11 (trap vector); otherwise 11 acts as PC+4.
module next_pc_sequencer
    import next_pc_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      next_pc_select,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_target,
    input  logic            retire,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            fetch_misaligned
);

    fetch_state_e    state_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;
    logic            inst_valid_r;
    logic            misaligned_r;

    logic [XLEN-1:0] trap_target_s;
    logic [XLEN-1:0] next_pc_s;
    logic [XLEN-1:0] pc_plus_4_s;
    logic            target_misaligned_s;

`ifdef NEXT_PC_TRAP_EN
    assign trap_target_s = trap_target;
`else
    logic unused_trap_port_s;
    assign unused_trap_port_s = ^trap_target;
    assign trap_target_s      = {XLEN{1'b0}};
`endif

    next_pc_mux #(
        .XLEN(XLEN)
    ) u_next_pc_mux (
        .pc             (pc_r),
        .next_pc_select (next_pc_select),
        .immediate      (immediate),
        .jalr_target    (jalr_target),
        .trap_target    (trap_target_s),
        .pc_plus_4      (pc_plus_4_s),
        .next_pc        (next_pc_s),
        .misaligned     (target_misaligned_s)
    );

    // Fetch FSM: request, wait for response, execute until retire, or halt on a bad target.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_INST;
            inst_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (imem_req_ready) begin
                        if (imem_rsp_valid) begin
                            inst_r       <= imem_rsp_data;
                            inst_valid_r <= 1'b1;
                            state_r      <= ST_EXEC;
                        end else begin
                            state_r <= ST_WAIT_RSP;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        inst_r       <= imem_rsp_data;
                        inst_valid_r <= 1'b1;
                        state_r      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        inst_valid_r <= 1'b0;
                        if (target_misaligned_s) begin
                            misaligned_r <= 1'b1;
                            state_r      <= ST_HALT;
                        end else begin
                            pc_r    <= next_pc_s;
                            state_r <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    inst_valid_r <= 1'b0;
                    state_r      <= ST_HALT;
                end
            endcase
        end
    end

    // Request is a decode of the state register, suppressed while reset is held.
    assign imem_req_valid   = (state_r == ST_REQ) & ~reset;
    assign imem_addr        = pc_r;
    assign pc               = pc_r;
    assign pc_plus_4        = pc_plus_4_s;
    assign inst             = inst_r;
    assign inst_valid       = inst_valid_r;
    assign fetch_misaligned = misaligned_r;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Self-checking bench for next_pc_sequencer: transaction-level model plus per-cycle compare.
module tb_next_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  next_pc_select = 2'b00;
    logic [31:0] immediate = 32'h0;
    logic [31:0] jalr_target = 32'h0;
    logic [31:0] trap_target = 32'h0;
    logic        retire = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        fetch_misaligned;

    next_pc_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .next_pc_select   (next_pc_select),
        .immediate        (immediate),
        .jalr_target      (jalr_target),
        .trap_target      (trap_target),
        .retire           (retire),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .pc               (pc),
        .pc_plus_4        (pc_plus_4),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model of the architecturally visible state after each clock edge.
    logic        live    = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_iv  = 1'b0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_inst = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Per-cycle compare of every output against the model, away from the active edge.
    always @(negedge clock) begin
        if (live) begin
            chk1("req_valid", imem_req_valid, exp_req);
            chk("imem_addr", imem_addr, exp_pc);
            chk("pc", pc, exp_pc);
            chk("pc_plus_4", pc_plus_4, exp_pc + 32'd4);
            chk1("inst_valid", inst_valid, exp_iv);
            chk("inst", inst, exp_inst);
            chk1("misaligned", fetch_misaligned, exp_mis);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fetch one instruction; rsp_wait 0 means response in the acceptance cycle.
    task automatic fetch(input int rdy_wait, input int rsp_wait);
        for (int i = 0; i < rdy_wait; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0000 | 32'(i);
            retire         = 1'b1;
            next_pc_select = 2'b01;
            immediate      = 32'h0000_0100;
            tick();
        end
        retire         = 1'b0;
        imem_req_ready = 1'b1;
        if (rsp_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(imem_addr);
            tick();
        end else begin
            imem_rsp_valid = 1'b0;
            tick();
            imem_req_ready = 1'b0;
            exp_req        = 1'b0;
            for (int i = 1; i < rsp_wait; i++) begin
                imem_rsp_data = 32'hDEAD_0000 | 32'(i);
                tick();
            end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(imem_addr);
            tick();
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        exp_req        = 1'b0;
        exp_iv         = 1'b1;
        exp_inst       = mem_word(exp_pc);
    endtask

    // Hold EXEC for exec_idle cycles under spurious responses, then retire.
    task automatic do_retire(input int exec_idle, input logic [1:0] sel, input logic [31:0] imm,
                             input logic [31:0] jt, input logic [31:0] tt);
        logic [31:0] target;
        logic        check;
        for (int i = 0; i < exec_idle; i++) begin
            imem_rsp_valid = 1'b1;
            imem_req_ready = 1'b1;
            imem_rsp_data  = 32'hFACE_0000 | 32'(i);
            tick();
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        retire         = 1'b1;
        next_pc_select = sel;
        immediate      = imm;
        jalr_target    = jt;
        trap_target    = tt;
        tick();
        retire = 1'b0;
        check  = 1'b1;
        case (sel)
            2'b00:   target = exp_pc + 32'd4;
            2'b01:   target = exp_pc + imm;
            2'b10:   target = {jt[31:1], 1'b0};
`ifdef NEXT_PC_TRAP_EN
            default: begin target = {tt[31:2], 2'b00}; check = 1'b0; end
`else
            default: target = exp_pc + 32'd4;
`endif
        endcase
        exp_iv = 1'b0;
        if (check && target[1:0] != 2'b00) begin
            exp_mis = 1'b1;
            exp_req = 1'b0;
        end else begin
            exp_pc  = target;
            exp_req = 1'b1;
        end
    endtask

    // One reset cycle, then a stale response in REQ that must be dropped.
    task automatic reset_dut();
        reset          = 1'b1;
        exp_req        = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBEEF_0001;
        tick();
        exp_pc   = RST_PC;
        exp_inst = NOP;
        exp_iv   = 1'b0;
        exp_mis  = 1'b0;
        reset          = 1'b0;
        exp_req        = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBEEF_0002;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        tick();
        exp_pc   = RST_PC;
        exp_inst = NOP;
        live     = 1'b1;
        tick();
        reset   = 1'b0;
        exp_req = 1'b1;
        chk("reset_pc", pc, 32'h0040_0000);
        chk("reset_inst", inst, 32'h0000_0013);

        fetch(0, 0);
        chk1("zero_wait_iv", inst_valid, 1'b1);
        do_retire(1, 2'b00, 32'h0, 32'h0, 32'h0);
        chk("plus4", pc, 32'h0040_0004);

        fetch(5, 3);
        chk("slow_inst", inst, mem_word(32'h0040_0004));
        do_retire(3, 2'b10, 32'h0, 32'h0040_0011, 32'h0);
        chk("jalr_bit0", pc, 32'h0040_0010);

        fetch(0, 1);
        do_retire(0, 2'b01, 32'hFFFF_FFF0, 32'h0, 32'h0);
        chk("imm_neg", pc, 32'h0040_0000);

        fetch(2, 0);
        do_retire(1, 2'b10, 32'h0, 32'hFFFF_FFFD, 32'h0);
        chk("jalr_top", pc, 32'hFFFF_FFFC);

        fetch(0, 2);
        do_retire(0, 2'b00, 32'h0, 32'h0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk1("wrap_mis", fetch_misaligned, 1'b0);

        fetch(0, 0);
        do_retire(0, 2'b11, 32'h0, 32'h0, 32'h0000_0105);
`ifdef NEXT_PC_TRAP_EN
        chk("trap_pc", pc, 32'h0000_0104);
`else
        chk("trap_pc", pc, 32'h0000_0004);
`endif

        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        exp_req        = 1'b0;
        tick();
        reset_dut();
        chk("midwait_pc", pc, 32'h0040_0000);
        chk1("midwait_iv", inst_valid, 1'b0);

        fetch(0, 0);
        do_retire(0, 2'b10, 32'h0, 32'h0040_0103, 32'h0);
        chk1("mis_flag", fetch_misaligned, 1'b1);
        chk("mis_pc", pc, 32'h0040_0000);
        for (int i = 0; i < 4; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            retire         = 1'b1;
            next_pc_select = 2'b00;
            tick();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        retire         = 1'b0;
        chk1("halt_no_req", imem_req_valid, 1'b0);

        reset_dut();
        fetch(0, 0);
        do_retire(0, 2'b00, 32'h0, 32'h0, 32'h0);
        chk("recover_pc", pc, 32'h0040_0004);
        chk1("recover_mis", fetch_misaligned, 1'b0);

        @(negedge clock);
        live = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
